noise_alarm: RTL and testbench
==============================

NOISE_ALARM -- requirements
Module: noise_alarm

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1000: observation window length in clk cycles (>=2).
REQ-002 SHALL have parameter THRESHOLD, default 4: number of events in one window that raises the alarm (1..255).
REQ-003 SHALL have parameter BLINK_HALF, default 50: LED half-period in clk cycles during alarm (>=1).
REQ-004 SHALL have parameter HOLD_WINDOWS, default 3: number of complete windows the alarm is held (>=1).
REQ-005 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port noise_in  input  1  latched noise level from the upstream noise latch; asynchronous to clk.
REQ-008 SHALL have port ack  input  1  synchronous operator acknowledge; active high.
REQ-009 SHALL have port event_pulse  output  1  one-cycle strobe per detected noise event.
REQ-010 SHALL have port event_count  output  8  event total of the last completed window.
REQ-011 SHALL have port alarm  output  1  high while in ALARM.
REQ-012 SHALL have port led  output  1  diode drive.

Function
REQ-013 SHALL pass noise_in through a 2-flop synchronizer, then a third flop for edge detection.
REQ-014 SHALL, if noise_in is low at edge k-1 and high at edge k, drive event_pulse high from edge k+2 to edge k+3 only; a held-high noise_in gives one pulse.
REQ-015 SHALL run a window counter 0..WINDOW_CYCLES-1 continuously in all states; the cycle with value WINDOW_CYCLES-1 is the wrap cycle.
REQ-016 SHALL increment an internal 8-bit event accumulator on each event_pulse cycle only in state MONITOR, saturating at 255.
REQ-017 SHALL, on the wrap cycle, load event_count with the accumulator value including any event_pulse of that same cycle, and clear the accumulator.
REQ-018 SHALL load event_count with 0 on wraps in ALARM or COOLDOWN.
REQ-019 SHALL implement states MONITOR, ALARM and COOLDOWN.
REQ-020 SHALL transition MONITOR->ALARM at the wrap cycle when the value loaded into event_count is >= THRESHOLD.
REQ-021 SHALL, in ALARM, count wraps and transition ALARM->COOLDOWN on the HOLD_WINDOWS-th wrap after entry.
REQ-022 SHALL transition ALARM->COOLDOWN at the edge where ack is high; ack SHALL be ignored in MONITOR and COOLDOWN.
REQ-023 SHALL transition COOLDOWN->MONITOR at the next wrap cycle; events during COOLDOWN are discarded.
REQ-024 SHALL, when ack and the HOLD_WINDOWS-th wrap coincide, go to COOLDOWN (same result either way).
REQ-025 SHALL drive alarm high exactly while the state is ALARM (registered, same edge as the state change).
REQ-026 SHALL drive led high on the edge entering ALARM, toggle every BLINK_HALF cycles while in ALARM, and drive it low in MONITOR and COOLDOWN.
REQ-027 SHALL restart the blink counter on every ALARM entry.
REQ-028 SHALL drive event_pulse independently of state; event_pulse continues in ALARM and COOLDOWN.

Reset
REQ-029 SHALL, while reset is high, asynchronously force: state MONITOR; window counter, accumulator, hold and blink counters 0; synchronizer flops 0; event_pulse 0, event_count 0, alarm 0, led 0.
REQ-030 SHALL, on reset asserted mid-alarm or mid-window, discard all partial counts; the first window after release starts at counter 0.

Verification (WINDOW_CYCLES=20, THRESHOLD=3, BLINK_HALF=2, HOLD_WINDOWS=2)
REQ-031 SHALL cover: noise_in high for 10 cycles from edge 5 -> exactly one event_pulse, high edges 7-8; event_count=1 after first wrap; alarm stays 0.
REQ-032 SHALL cover: 3 separated pulses in window 0 -> event_count=3 and alarm=1, led=1 after edge of cycle 19; led toggles every 2 cycles; alarm drops after 2 further wraps; returns to MONITOR one wrap later.
REQ-033 SHALL cover: 2 pulses early plus third event_pulse landing exactly on the wrap cycle -> counted, event_count=3, alarm raised.
REQ-034 SHALL cover: ack high one cycle, 5 cycles into ALARM -> alarm=0 and led=0 next edge; pulses during COOLDOWN do not change next event_count (0).
REQ-035 SHALL cover: reset asserted for 1 cycle mid-ALARM with led=1 -> alarm, led, event_count read 0 immediately (asynchronously); next window counts from scratch.
REQ-036 SHALL cover: 300 events in one window (WINDOW_CYCLES=2000) -> event_count saturates at 255.

Source files
------------

// File: rtl/noise_alarm.sv
// noise_alarm: counts noise events per fixed observation window and raises a
// blinking alarm when a window collects THRESHOLD or more events. The alarm
// holds for HOLD_WINDOWS complete windows or until the operator acknowledges.
// It then spends one cooldown window, whose events are discarded, before
// monitoring resumes.
//
// Handshake note: there is no valid/ready pair on this block. event_pulse is
// a one-cycle strobe with no back-pressure. ack is a level sampled on every
// clk edge and acted on only in ALARM.
//
// The FSM state is held in the signal "state", so checkers can bind to it.
module noise_alarm #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int THRESHOLD     = 4,
  parameter int BLINK_HALF    = 50,
  parameter int HOLD_WINDOWS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noise_in,
  input  logic       ack,
  output logic       event_pulse,
  output logic [7:0] event_count,
  output logic       alarm,
  output logic       led
);

  localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam int HD_W = $clog2(HOLD_WINDOWS + 1);

  localparam logic [WC_W-1:0] WRAP_VAL   = WC_W'(WINDOW_CYCLES - 1);
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_HALF - 1);
  localparam logic [HD_W-1:0] HOLD_LAST  = HD_W'(HOLD_WINDOWS - 1);
  localparam logic [7:0]      THRESH     = 8'(THRESHOLD);

  typedef enum logic [1:0] {
    ST_MONITOR  = 2'd0,
    ST_ALARM    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            sync_1;
  logic            sync_2;
  logic            sync_3;
  logic [WC_W-1:0] win_cnt;
  logic            wrap;
  logic [7:0]      acc;
  logic [7:0]      acc_sum;
  logic            count_en;
  logic [HD_W-1:0] hold_cnt;
  logic [BL_W-1:0] blink_cnt;
  logic [BL_W-1:0] blink_d;
  logic            led_d;
  logic            alarm_d;

  // Two flops bring noise_in into the clk domain; a third gives the previous
  // level, so a rising edge gives exactly one registered strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      sync_3      <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      sync_1      <= noise_in;
      sync_2      <= sync_1;
      sync_3      <= sync_2;
      event_pulse <= sync_2 & ~sync_3;
    end
  end

  // The window counter runs freely in every state; its last value marks the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
    end else if (wrap) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  assign wrap     = (win_cnt == WRAP_VAL);
  assign count_en = (state == ST_MONITOR);
  // A strobe on the wrap cycle still belongs to the window that is closing.
  assign acc_sum  = (event_pulse && (acc != 8'hFF)) ? acc + 8'd1 : acc;

  // Accumulate events while monitoring; publish and clear at every wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= 8'd0;
      event_count <= 8'd0;
    end else if (wrap) begin
      acc         <= 8'd0;
      event_count <= count_en ? acc_sum : 8'd0;
    end else if (count_en) begin
      acc         <= acc_sum;
    end
  end

  // Count wraps seen in ALARM; the count stays at zero outside ALARM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state != ST_ALARM) begin
      hold_cnt <= '0;
    end else if (wrap) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_MONITOR;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. In ALARM, ack and the final hold wrap lead to the same state.
  always_comb begin
    state_next = state;
    case (state)
      ST_MONITOR:  if (wrap && (acc_sum >= THRESH)) state_next = ST_ALARM;
      ST_ALARM:    if (ack || (wrap && (hold_cnt == HOLD_LAST))) state_next = ST_COOLDOWN;
      ST_COOLDOWN: if (wrap) state_next = ST_MONITOR;
      default:     state_next = ST_MONITOR;
    endcase
  end

  // FSM output logic. The LED starts lit on entry and toggles every BLINK_HALF cycles.
  always_comb begin
    alarm_d = (state_next == ST_ALARM);
    led_d   = 1'b0;
    blink_d = '0;
    if (state_next == ST_ALARM) begin
      if (state != ST_ALARM) begin
        led_d   = 1'b1;
        blink_d = '0;
      end else if (blink_cnt == BLINK_LAST) begin
        led_d   = ~led;
        blink_d = '0;
      end else begin
        led_d   = led;
        blink_d = blink_cnt + 1'b1;
      end
    end
  end

  // Register the outputs so that alarm and led change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm     <= 1'b0;
      led       <= 1'b0;
      blink_cnt <= '0;
    end else begin
      alarm     <= alarm_d;
      led       <= led_d;
      blink_cnt <= blink_d;
    end
  end

endmodule

// File: tb/tb_noise_alarm.sv
// tb_noise_alarm: directed scenarios for noise_alarm. A small config
// (window 20, threshold 3, blink 2, hold 2) covers the main behaviour. A
// second instance with a 2000-cycle window covers accumulator saturation.
// Inputs are driven and outputs sampled on the falling clk edge. cyc counts
// rising edges since the last reset release, so cyc == 20 is the first wrap edge.
module tb_noise_alarm;

  localparam int WIN = 20;

  logic       clk;
  logic       reset;
  logic       noise_in;
  logic       ack;
  logic       event_pulse;
  logic [7:0] event_count;
  logic       alarm;
  logic       led;

  logic       noise_sat;
  logic       ack_sat;
  logic       event_pulse_sat;
  logic [7:0] event_count_sat;
  logic       alarm_sat;
  logic       led_sat;

  int         cyc;
  int         pulse_cnt;
  int         sat_pulse_cnt;
  int         n_checks;
  int         n_pass;
  logic [7:0] exp_q[$];

  noise_alarm #(
    .WINDOW_CYCLES(WIN), .THRESHOLD(3), .BLINK_HALF(2), .HOLD_WINDOWS(2)
  ) dut (
    .clk(clk), .reset(reset), .noise_in(noise_in), .ack(ack),
    .event_pulse(event_pulse), .event_count(event_count), .alarm(alarm), .led(led)
  );

  noise_alarm #(
    .WINDOW_CYCLES(2000), .THRESHOLD(3), .BLINK_HALF(2), .HOLD_WINDOWS(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .noise_in(noise_sat), .ack(ack_sat),
    .event_pulse(event_pulse_sat), .event_count(event_count_sat),
    .alarm(alarm_sat), .led(led_sat)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
  endtask

  // One clock: move to the next falling edge, then update counters and the scoreboard.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    pulse_cnt     += int'(event_pulse);
    sat_pulse_cnt += int'(event_pulse_sat);
    if (!reset && (cyc % WIN == 0) && (exp_q.size() > 0))
      check("event_count_wrap", event_count, exp_q.pop_front());
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // noise_in goes high at edge start+1 and low at edge start+len+1.
  task automatic noise_burst(input int start, input int len);
    run_to(start);
    noise_in = 1'b1;
    run_to(start + len);
    noise_in = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    noise_in  = 1'b0;
    noise_sat = 1'b0;
    ack       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_event_pulse", event_pulse, 0);
    check("rst_event_count", event_count, 0);
    check("rst_alarm", alarm, 0);
    check("rst_led", led, 0);
    reset         = 1'b0;
    cyc           = 0;
    pulse_cnt     = 0;
    sat_pulse_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    ack_sat  = 1'b0;
    @(negedge clk);

    // Held-high noise gives a single pulse on edges 7-8 and no alarm.
    do_reset();
    exp_q.push_back(8'd1);
    run_to(4);
    noise_in = 1'b1;
    run_to(6);
    check("pulse_before", event_pulse, 0);
    run_to(7);
    check("pulse_edge7", event_pulse, 1);
    run_to(8);
    check("pulse_edge8_low", event_pulse, 0);
    run_to(14);
    noise_in = 1'b0;
    run_to(WIN);
    check("single_pulse_cnt", pulse_cnt, 1);
    check("no_alarm_1evt", alarm, 0);

    // Three events raise the alarm; the LED blinks, the alarm holds for two wraps, then cooldown.
    do_reset();
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    noise_burst(1, 2);
    noise_burst(6, 2);
    noise_burst(11, 2);
    run_to(19);
    check("alarm_pre_wrap", alarm, 0);
    run_to(20);
    check("alarm_raised", alarm, 1);
    check("led_on_entry", led, 1);
    run_to(21);
    check("led_hold", led, 1);
    run_to(22);
    check("led_toggle_off", led, 0);
    run_to(24);
    check("led_toggle_on", led, 1);
    run_to(59);
    check("alarm_held", alarm, 1);
    run_to(60);
    check("alarm_dropped", alarm, 0);
    check("led_off_cooldown", led, 0);
    noise_burst(64, 2);
    noise_burst(84, 2);
    run_to(100);
    check("monitor_resumed_alarm", alarm, 0);

    // A third pulse on the wrap cycle is counted; ack 5 cycles into ALARM ends it.
    do_reset();
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd3);
    noise_burst(1, 2);
    noise_burst(6, 2);
    noise_burst(16, 2);
    run_to(19);
    check("pulse_on_wrap", event_pulse, 1);
    run_to(20);
    check("alarm_wrap_evt", alarm, 1);
    run_to(25);
    check("alarm_before_ack", alarm, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("alarm_after_ack", alarm, 0);
    check("led_after_ack", led, 0);
    noise_burst(28, 2);
    run_to(40);
    check("cooldown_no_alarm", alarm, 0);
    // Ack while monitoring has no effect; three events raise the alarm again.
    noise_burst(41, 2);
    run_to(45);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    noise_burst(46, 2);
    noise_burst(51, 2);
    run_to(60);
    check("alarm_again", alarm, 1);
    run_to(61);
    check("led_lit_before_rst", led, 1);

    // Reset in the middle of ALARM clears the outputs at once, before the next clk edge.
    reset = 1'b1;
    #1;
    check("async_alarm", alarm, 0);
    check("async_led", led, 0);
    check("async_event_count", event_count, 0);
    @(negedge clk);
    reset         = 1'b0;
    cyc           = 0;
    pulse_cnt     = 0;
    sat_pulse_cnt = 0;
    exp_q.delete();
    exp_q.push_back(8'd1);
    noise_burst(3, 2);
    run_to(10);
    check("count_cleared", event_count, 0);
    run_to(WIN);
    check("post_rst_alarm", alarm, 0);

    // 300 events in one 2000-cycle window saturate the count at 255.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      noise_sat = ~noise_sat;
      tick();
    end
    noise_sat = 1'b0;
    run_to(2000);
    check("sat_pulses", sat_pulse_cnt, 300);
    check("sat_count", event_count_sat, 255);
    check("sat_alarm", alarm_sat, 1);
    check("sat_led", led_sat, 1);

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
